clk_div_gen: RTL and testbench
==============================

CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
REQ-001 Parameter CNT_W, default 8: width of the phase-length inputs.
REQ-002 Parameter BURST_W, default 8: width of the burst-length input.
REQ-003 clk  in  1  system clock; all logic on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 en  in  1  free-run enable; level-sensitive.
REQ-006 mode  in  1  0 = free-run, 1 = burst; sampled only in IDLE.
REQ-007 start  in  1  burst launch pulse; sampled only in IDLE with mode=1.
REQ-008 half_hi  in  CNT_W  HIGH-phase length in clk cycles; 0 treated as 1.
REQ-009 half_lo  in  CNT_W  LOW-phase length in clk cycles; 0 treated as 1.
REQ-010 burst_len  in  BURST_W  number of output periods per burst.
REQ-011 clk_out  out  1  generated clock, registered.
REQ-012 rise  out  1  one-cycle strobe in the cycle where clk_out first reads 1 after 0.
REQ-013 fall  out  1  one-cycle strobe in the cycle where clk_out first reads 0 after 1.
REQ-014 busy  out  1  high whenever the FSM is not IDLE.
REQ-015 done  out  1  one-cycle pulse when a burst completes.

Function
REQ-016 The FSM SHALL have three states: IDLE, HIGH and LOW. clk_out is 0 in IDLE and LOW and 1 in HIGH.
REQ-017 IDLE->HIGH SHALL occur on the edge sampling (mode=0, en=1) or (mode=1, start=1, burst_len!=0). clk_out=1 and rise=1 the next cycle (1-cycle latency).
REQ-018 Phase lengths SHALL be latched at each phase entry: HIGH lasts max(half_hi,1) cycles and LOW lasts max(half_lo,1) cycles. Mid-phase input changes take effect at the next phase entry.
REQ-019 HIGH->LOW SHALL occur when the phase counter expires, with fall=1 in the first LOW cycle.
REQ-020 Free-run: on LOW expiry, go to HIGH if en=1, else go to IDLE. Dropping en SHALL never truncate a HIGH or LOW phase (no runt pulses).
REQ-021 Burst: the burst counter loads burst_len at launch and decrements on each LOW expiry. When it reaches 0, go to IDLE and assert done for exactly 1 cycle, in the first IDLE cycle. en is ignored during a burst.
REQ-022 start with mode=1 and burst_len=0 SHALL produce no clk_out activity, keep busy=0, and pulse done in the next cycle.
REQ-023 start, and changes to mode, SHALL be ignored while busy=1.
REQ-024 The phase counter SHALL be CNT_W bits and the burst counter BURST_W bits. Maximum values (2^CNT_W-1, 2^BURST_W-1) SHALL work without wrap errors.

Reset
REQ-025 rst=1 SHALL, on the next edge: force state to IDLE, clear clk_out, rise, fall, busy and done, and clear both counters.
REQ-026 rst asserted mid-phase or mid-burst SHALL abort immediately, with no done pulse and no trailing edge strobe.
REQ-027 After rst deasserts, the first possible clk_out rise is one cycle after a qualifying en/start sample.

Configuration
REQ-028 Macro CLK_DIV_GEN_BURST_EN SHALL compile in burst mode: the start input, the burst counter and done generation.
REQ-029 Without CLK_DIV_GEN_BURST_EN: mode and start are ignored (behaviour as mode=0), burst_len is unused, done is tied 0, and all ports remain present.

Verification
REQ-030 half_hi=5, half_lo=5, mode=0, en=1 -> clk_out period 10, 5 high / 5 low; rise every 10 cycles; busy=1 throughout.
REQ-031 half_hi=3, half_lo=1 -> 3 high / 1 low, period 4. Then half_hi=0, half_lo=0 -> period 2, the same result as 1/1.
REQ-032 Burst mode, half_hi=2, half_lo=2, burst_len=10, single start -> exactly 10 rise strobes, busy=1 for 40 cycles, one done pulse, then clk_out=0.
REQ-033 Free-run with half_hi=4, half_lo=4; en dropped in the 2nd HIGH cycle -> HIGH runs its full 4 cycles, LOW its full 4, then IDLE; no extra rise.
REQ-034 rst pulsed at the 5th rise of a burst_len=8 burst -> next cycle clk_out=0, busy=0, done never asserts. A new start then gives a full 8-period burst.
REQ-035 Build without CLK_DIV_GEN_BURST_EN: start with mode=1 and en=0 -> clk_out stays 0 and done stays 0. With en=1 -> free-run per REQ-030.

Source files
------------

// File: rtl/clk_div_gen_if.sv
// Bus bundle for clk_div_gen: enable/launch controls, phase and burst lengths,
// and the generated clock with its edge strobes and status.
interface clk_div_gen_if #(
    parameter int CNT_W   = 8,
    parameter int BURST_W = 8
);
    logic               en;
    logic               mode;
    logic               start;
    logic [CNT_W-1:0]   half_hi;
    logic [CNT_W-1:0]   half_lo;
    logic [BURST_W-1:0] burst_len;
    logic               clk_out;
    logic               rise;
    logic               fall;
    logic               busy;
    logic               done;

    modport master (
        output en, mode, start, half_hi, half_lo, burst_len,
        input  clk_out, rise, fall, busy, done
    );

    modport slave (
        input  en, mode, start, half_hi, half_lo, burst_len,
        output clk_out, rise, fall, busy, done
    );
endinterface

// File: rtl/clk_div_gen.sv
// Programmable clock divider: free-running or counted-burst output clock with edge strobes.
// Define CLK_DIV_GEN_BURST_EN to build burst mode (start, burst counter, done pulse).
module clk_div_gen #(
    parameter int CNT_W   = 8,
    parameter int BURST_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    clk_div_gen_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] phaseCnt_q;
    logic             clkOut_q;
    logic             rise_q;
    logic             fall_q;
    logic             busy_q;

    logic [CNT_W-1:0] hiLoad_d;
    logic [CNT_W-1:0] loLoad_d;
    logic             launchRun_d;
    logic             keepRunning_d;

    // The phase counter holds remaining cycles minus one, so a zero length acts as one.
    assign hiLoad_d = (bus.half_hi == '0) ? '0 : bus.half_hi - CNT_W'(1);
    assign loLoad_d = (bus.half_lo == '0) ? '0 : bus.half_lo - CNT_W'(1);

`ifdef CLK_DIV_GEN_BURST_EN
    logic               burstMode_q;
    logic               done_q;
    logic [BURST_W-1:0] burstCnt_q;
    logic               launchBurst_d;
    logic               emptyBurst_d;

    assign launchBurst_d = bus.mode & bus.start & (bus.burst_len != '0);
    assign emptyBurst_d  = bus.mode & bus.start & (bus.burst_len == '0);
    assign launchRun_d   = (~bus.mode & bus.en) | launchBurst_d;
    // A burst ends when the period now finishing was the last one counted.
    assign keepRunning_d = burstMode_q ? (burstCnt_q != BURST_W'(1)) : bus.en;
    assign bus.done      = done_q;
`else
    logic unusedBurstInputs;

    assign unusedBurstInputs = ^{bus.mode, bus.start, bus.burst_len};
    assign launchRun_d       = bus.en;
    assign keepRunning_d     = bus.en;
    assign bus.done          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            phaseCnt_q  <= '0;
            clkOut_q    <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            busy_q      <= 1'b0;
`ifdef CLK_DIV_GEN_BURST_EN
            burstMode_q <= 1'b0;
            burstCnt_q  <= '0;
            done_q      <= 1'b0;
`endif
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
`ifdef CLK_DIV_GEN_BURST_EN
            done_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (launchRun_d) begin
                        state_q     <= HIGH;
                        phaseCnt_q  <= hiLoad_d;
                        clkOut_q    <= 1'b1;
                        rise_q      <= 1'b1;
                        busy_q      <= 1'b1;
`ifdef CLK_DIV_GEN_BURST_EN
                        burstMode_q <= launchBurst_d;
                        burstCnt_q  <= launchBurst_d ? bus.burst_len : '0;
                    end else if (emptyBurst_d) begin
                        done_q      <= 1'b1;
`endif
                    end
                end
                HIGH: begin
                    if (phaseCnt_q == '0) begin
                        state_q    <= LOW;
                        phaseCnt_q <= loLoad_d;
                        clkOut_q   <= 1'b0;
                        fall_q     <= 1'b1;
                    end else begin
                        phaseCnt_q <= phaseCnt_q - CNT_W'(1);
                    end
                end
                LOW: begin
                    // Decisions are only taken at the end of a full LOW phase, so no runt pulses.
                    if (phaseCnt_q == '0) begin
                        if (keepRunning_d) begin
                            state_q    <= HIGH;
                            phaseCnt_q <= hiLoad_d;
                            clkOut_q   <= 1'b1;
                            rise_q     <= 1'b1;
                        end else begin
                            state_q    <= IDLE;
                            busy_q     <= 1'b0;
`ifdef CLK_DIV_GEN_BURST_EN
                            done_q     <= burstMode_q;
`endif
                        end
`ifdef CLK_DIV_GEN_BURST_EN
                        if (burstMode_q) begin
                            burstCnt_q <= burstCnt_q - BURST_W'(1);
                        end
`endif
                    end else begin
                        phaseCnt_q <= phaseCnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    clkOut_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.clk_out = clkOut_q;
    assign bus.rise    = rise_q;
    assign bus.fall    = fall_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: directed scenarios plus random stimulus against
// a waveform-queue reference model; burst expectations follow CLK_DIV_GEN_BURST_EN.
module tb_clk_div_gen;
    localparam int CNT_W   = 8;
    localparam int BURST_W = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    clk_div_gen_if #(.CNT_W(CNT_W), .BURST_W(BURST_W)) bus ();

    clk_div_gen #(.CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checkCount = 0;
    int passCount  = 0;
    int riseSeen   = 0;
    int doneSeen   = 0;

    // Reference model: a queue of future output levels, refilled one phase at a time.
    bit wave[$];
    bit prevLevel   = 1'b0;
    bit running     = 1'b0;
    bit inBurst     = 1'b0;
    int periodsLeft = 0;
    bit expClk, expRise, expFall, expBusy, expDone;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, actual, expected);
        end
    endtask

    task automatic pushLevel(input bit level, input int cycles);
        for (int k = 0; k < cycles; k++) wave.push_back(level);
    endtask

    task automatic modelEdge();
        int hi;
        int lo;
        bit level;
        expDone = 1'b0;
        if (rst) begin
            wave.delete();
            running     = 1'b0;
            inBurst     = 1'b0;
            periodsLeft = 0;
            prevLevel   = 1'b0;
            expClk      = 1'b0;
            expRise     = 1'b0;
            expFall     = 1'b0;
            expBusy     = 1'b0;
            return;
        end
        hi = (bus.half_hi == 0) ? 1 : int'(bus.half_hi);
        lo = (bus.half_lo == 0) ? 1 : int'(bus.half_lo);
        if (wave.size() == 0) begin
            if (running && prevLevel) begin
                pushLevel(1'b0, lo);
            end else if (running) begin
                if (inBurst) begin
                    periodsLeft--;
                    if (periodsLeft > 0) pushLevel(1'b1, hi);
                    else begin
                        running = 1'b0;
                        expDone = 1'b1;
                    end
                end else if (bus.en) begin
                    pushLevel(1'b1, hi);
                end else begin
                    running = 1'b0;
                end
            end else begin
`ifdef CLK_DIV_GEN_BURST_EN
                if (!bus.mode && bus.en) begin
                    running = 1'b1;
                    inBurst = 1'b0;
                    pushLevel(1'b1, hi);
                end else if (bus.mode && bus.start && bus.burst_len != 0) begin
                    running     = 1'b1;
                    inBurst     = 1'b1;
                    periodsLeft = int'(bus.burst_len);
                    pushLevel(1'b1, hi);
                end else if (bus.mode && bus.start) begin
                    expDone = 1'b1;
                end
`else
                if (bus.en) begin
                    running = 1'b1;
                    inBurst = 1'b0;
                    pushLevel(1'b1, hi);
                end
`endif
            end
        end
        level   = (wave.size() != 0) ? wave.pop_front() : 1'b0;
        expClk  = level;
        expRise = level && !prevLevel;
        expFall = !level && prevLevel;
        expBusy = running;
        prevLevel = level;
    endtask

    // Advance n clock edges with the inputs as currently driven, checking every cycle.
    task automatic applyStimulus(input int n);
        for (int c = 0; c < n; c++) begin
            modelEdge();
            @(negedge clk);
            if (bus.rise === 1'b1) riseSeen++;
            if (bus.done === 1'b1) doneSeen++;
            checkOutput("clk_out", bus.clk_out, expClk);
            checkOutput("rise",    bus.rise,    expRise);
            checkOutput("fall",    bus.fall,    expFall);
            checkOutput("busy",    bus.busy,    expBusy);
            checkOutput("done",    bus.done,    expDone);
        end
    endtask

    initial begin
        int expBurstRises;
        int expBurstDones;
        rst           = 1'b1;
        bus.en        = 1'b0;
        bus.mode      = 1'b0;
        bus.start     = 1'b0;
        bus.half_hi   = '0;
        bus.half_lo   = '0;
        bus.burst_len = '0;
        applyStimulus(2);

        // Free-run 5/5: one rise every 10 cycles.
        rst = 1'b0;
        bus.half_hi = 8'd5;
        bus.half_lo = 8'd5;
        bus.en      = 1'b1;
        riseSeen    = 0;
        applyStimulus(40);
        checkOutput("rise_count_5_5", riseSeen, 4);

        bus.half_hi = 8'd3;
        bus.half_lo = 8'd1;
        applyStimulus(16);
        bus.half_hi = 8'd0;
        bus.half_lo = 8'd0;
        applyStimulus(10);

        // Drop en in the second HIGH cycle of a 4/4 period.
        bus.en      = 1'b0;
        bus.half_hi = 8'd4;
        bus.half_lo = 8'd4;
        applyStimulus(12);
        bus.en = 1'b1;
        applyStimulus(2);
        bus.en   = 1'b0;
        riseSeen = 0;
        applyStimulus(12);
        checkOutput("no_extra_rise", riseSeen, 0);

`ifdef CLK_DIV_GEN_BURST_EN
        expBurstRises = 10;
        expBurstDones = 1;
`else
        expBurstRises = 0;
        expBurstDones = 0;
`endif
        // Single burst of 10 periods at 2/2.
        bus.mode      = 1'b1;
        bus.half_hi   = 8'd2;
        bus.half_lo   = 8'd2;
        bus.burst_len = 8'd10;
        bus.start     = 1'b1;
        riseSeen      = 0;
        doneSeen      = 0;
        applyStimulus(1);
        bus.start = 1'b0;
        applyStimulus(44);
        checkOutput("burst_rises", riseSeen, expBurstRises);
        checkOutput("burst_dones", doneSeen, expBurstDones);

        // Reset at the 5th rise of an 8-period burst, then a full burst.
        bus.burst_len = 8'd8;
        bus.start     = 1'b1;
        applyStimulus(1);
        bus.start = 1'b0;
        applyStimulus(16);
        rst = 1'b1;
        applyStimulus(1);
        rst = 1'b0;
        doneSeen = 0;
        applyStimulus(3);
        checkOutput("no_done_after_abort", doneSeen, 0);
        bus.start = 1'b1;
        applyStimulus(1);
        bus.start = 1'b0;
        applyStimulus(36);

        bus.burst_len = 8'd0;
        bus.start     = 1'b1;
        applyStimulus(1);
        bus.start = 1'b0;
        applyStimulus(3);

        // Maximum phase and burst lengths.
        bus.mode    = 1'b0;
        bus.en      = 1'b1;
        bus.half_hi = 8'd255;
        bus.half_lo = 8'd255;
        applyStimulus(520);
        bus.en = 1'b0;
        applyStimulus(520);
        bus.mode      = 1'b1;
        bus.half_hi   = 8'd1;
        bus.half_lo   = 8'd0;
        bus.burst_len = 8'd255;
        bus.start     = 1'b1;
        applyStimulus(1);
        bus.start = 1'b0;
        applyStimulus(515);

        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0)  bus.en   = ~bus.en;
            if ($urandom_range(0, 19) == 0) bus.mode = ~bus.mode;
            bus.start = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 11) == 0) bus.half_hi   = CNT_W'($urandom_range(0, 6));
            if ($urandom_range(0, 11) == 0) bus.half_lo   = CNT_W'($urandom_range(0, 6));
            if ($urandom_range(0, 11) == 0) bus.burst_len = BURST_W'($urandom_range(0, 5));
            applyStimulus(1);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
